// File: rtl/alu_pkg.sv
// Shared encodings for the execution-stage ALU and the ALU control decoder.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_MUL = 4'd2;
    localparam logic [3:0] ALU_SLL = 4'd3;
    localparam logic [3:0] ALU_SRL = 4'd4;
    localparam logic [3:0] ALU_AND = 4'd5;
    localparam logic [3:0] ALU_OR  = 4'd6;
    localparam logic [3:0] ALU_SLT = 4'd7;
    localparam logic [3:0] ALU_XOR = 4'd8;
    localparam logic [3:0] ALU_INV = 4'd9;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } alu_state_e;

endpackage

// File: rtl/seq_multiplier.sv
// Shift-add multiplier: one partial product per step, WIDTH steps per product.
// product/done are combinational views of the step currently being taken, so
// the owner can register the final sum on the same edge as the last add.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] mcand_init,
    input  logic [WIDTH-1:0] mplier_init,
    output logic [WIDTH-1:0] product,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] count;

    // Accumulator value after this step's conditional add.
    assign product = mplier[0] ? (acc + mcand) : acc;
    assign done    = step && (count == LAST);

    // Load operands on accept, then shift one multiplier bit per step.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (load) begin
            mcand  <= mcand_init;
            mplier <= mplier_init;
            acc    <= '0;
            count  <= '0;
        end else if (step) begin
            acc    <= product;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end
    end

endmodule

// File: rtl/alu_core.sv
// Registered execution-stage ALU with a multi-cycle shift-add multiply.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | ready=1; single-cycle ops complete here, MUL accept loads
// ST_MUL  | ready=0; one shift-add iteration per cycle until done
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_cnt,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             valid
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_e       state;
    logic [WIDTH-1:0] alu_out;
    logic [SHW-1:0]   shamt;
    logic             mul_load;
    logic             mul_step;
    logic [WIDTH-1:0] mul_product;
    logic             mul_done;

    assign ready    = (state == ST_IDLE);
    assign shamt    = op_b[SHW-1:0];
    assign mul_load = ready && start && (alu_cnt == ALU_MUL);
    assign mul_step = (state == ST_MUL);

    // Single-cycle datapath; MUL and unused codes fall through to zero.
    always_comb begin
        alu_out = '0;
        case (alu_cnt)
            ALU_ADD: alu_out = op_a + op_b;
            ALU_SUB: alu_out = op_a - op_b;
            ALU_SLL: alu_out = op_a << shamt;
            ALU_SRL: alu_out = op_a >> shamt;
            ALU_AND: alu_out = op_a & op_b;
            ALU_OR:  alu_out = op_a | op_b;
            ALU_SLT: alu_out = ($signed(op_a) < $signed(op_b)) ? WIDTH'(1) : '0;
            ALU_XOR: alu_out = op_a ^ op_b;
            ALU_INV: alu_out = ~op_a;
            default: alu_out = '0;
        endcase
    end

    seq_multiplier #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (mul_load),
        .step       (mul_step),
        .mcand_init (op_a),
        .mplier_init(op_b),
        .product    (mul_product),
        .done       (mul_done)
    );

    // Issue/complete FSM with registered result, zero flag and valid strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            result <= '0;
            zero   <= 1'b1;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (alu_cnt == ALU_MUL) begin
                            state <= ST_MUL;
                        end else begin
                            result <= alu_out;
                            zero   <= (alu_out == '0);
                            valid  <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        result <= mul_product;
                        zero   <= (mul_product == '0);
                        valid  <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
